// File: rtl/pipe_inst_queue.sv
// Instruction queue between fetch and decode.
// First-word-fall-through FIFO with flush and sticky overflow.
module pipe_inst_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic [WIDTH-1:0] NOP = '0
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_inst,
  input  logic                     pop,
  output logic [WIDTH-1:0]         out_inst,
  output logic                     out_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    wrPtr;
  logic [CW-1:0]    cnt;
  logic             ovfQ;
  logic             doPop;
  logic             doPush;
  logic             isFull;
  logic             isEmpty;

  assign isEmpty = (cnt == '0);
  assign isFull  = (cnt == CW'(DEPTH));

  // A full queue still takes a push when a pop frees the head slot.
  assign doPop  = pop && !isEmpty;
  assign doPush = push && (!isFull || doPop);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rdPtr <= '0;
      wrPtr <= '0;
      cnt   <= '0;
      ovfQ  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= NOP;
      end
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      cnt   <= '0;
      ovfQ  <= 1'b0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= push_inst;
        wrPtr      <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      unique case (1'b1)
        doPush && !doPop: cnt <= cnt + CW'(1);
        doPop && !doPush: cnt <= cnt - CW'(1);
        default:          cnt <= cnt;
      endcase
      if (push && !doPush) begin
        ovfQ <= 1'b1;
      end
    end
  end

  assign out_valid = !isEmpty;
  assign full      = isFull;
  assign count     = cnt;
  assign ovf       = ovfQ;
  assign out_inst  = isEmpty ? NOP : mem[rdPtr];

endmodule

// File: tb/tb_pipe_inst_queue.sv
// Directed bench for pipe_inst_queue.
// Hand-computed expectations, default parameters.
module tb_pipe_inst_queue;

  logic        clk;
  logic        clrn;
  logic        flush;
  logic        push;
  logic [31:0] push_inst;
  logic        pop;
  logic [31:0] out_inst;
  logic        out_valid;
  logic        full;
  logic [2:0]  count;
  logic        ovf;

  int tests;
  int fails;

  pipe_inst_queue dut (
    .clk       (clk),
    .clrn      (clrn),
    .flush     (flush),
    .push      (push),
    .push_inst (push_inst),
    .pop       (pop),
    .out_inst  (out_inst),
    .out_valid (out_valid),
    .full      (full),
    .count     (count),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag,
                           input logic [31:0] eInst,
                           input logic eValid,
                           input logic eFull,
                           input logic [2:0] eCount,
                           input logic eOvf);
    check({tag, ".inst"},  out_inst, eInst);
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, eValid});
    check({tag, ".full"},  {31'd0, full}, {31'd0, eFull});
    check({tag, ".count"}, {29'd0, count}, {29'd0, eCount});
    check({tag, ".ovf"},   {31'd0, ovf}, {31'd0, eOvf});
  endtask

  task automatic step(input logic pu,
                      input logic [31:0] d,
                      input logic po,
                      input logic fl);
    push      = pu;
    push_inst = d;
    pop       = po;
    flush     = fl;
    @(posedge clk);
    #1;
    push      = 1'b0;
    push_inst = 32'hDEAD_BEEF;
    pop       = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    clrn      = 1'b0;
    flush     = 1'b0;
    push      = 1'b0;
    push_inst = '0;
    pop       = 1'b0;

    #12;
    chk_state("reset", 32'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    clrn = 1'b1;
    @(posedge clk);
    #1;

    // Single push, latency 1
    step(1'b1, 32'h1111_1111, 1'b0, 1'b0);
    chk_state("push1", 32'h1111_1111, 1'b1, 1'b0, 3'd1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk_state("pop1", 32'h0, 1'b0, 1'b0, 3'd0, 1'b0);

    // Fill, overflow, drain
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'hA0 + i, 1'b0, 1'b0);
    end
    chk_state("fillA", 32'hA0, 1'b1, 1'b1, 3'd4, 1'b0);
    step(1'b1, 32'hA4, 1'b0, 1'b0);
    chk_state("ovfA", 32'hA0, 1'b1, 1'b1, 3'd4, 1'b1);
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check("drainA.inst", out_inst, 32'hA0 + i);
      check("drainA.count", {29'd0, count}, 32'(4 - i));
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk_state("emptyA", 32'h0, 1'b0, 1'b0, 3'd0, 1'b1);

    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk_state("flush0", 32'h0, 1'b0, 1'b0, 3'd0, 1'b0);

    // Full with simultaneous push and pop, wrapping
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'hD0 + i, 1'b0, 1'b0);
    end
    step(1'b1, 32'hB0, 1'b1, 1'b0);
    chk_state("fullPP", 32'hD1, 1'b1, 1'b1, 3'd4, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("wrap.d2", out_inst, 32'hD2);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("wrap.d3", out_inst, 32'hD3);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk_state("wrap.b0", 32'hB0, 1'b1, 1'b0, 3'd1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk_state("wrap.end", 32'h0, 1'b0, 1'b0, 3'd0, 1'b0);

    // count=3 with ovf set, then flush+push+pop
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'hE0 + i, 1'b0, 1'b0);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk_state("pre3", 32'hE1, 1'b1, 1'b0, 3'd3, 1'b1);
    step(1'b1, 32'hF0, 1'b1, 1'b1);
    chk_state("flushPP", 32'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk_state("flushIdle", 32'h0, 1'b0, 1'b0, 3'd0, 1'b0);

    // Pop on empty, then push+pop on empty
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk_state("emptyPop", 32'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    step(1'b1, 32'hC0, 1'b1, 1'b0);
    chk_state("emptyPP", 32'hC0, 1'b1, 1'b0, 3'd1, 1'b0);
    step(1'b1, 32'hC1, 1'b0, 1'b0);
    check("cnt2", {29'd0, count}, 32'd2);

    // Asynchronous reset between edges
    #2;
    clrn = 1'b0;
    #1;
    chk_state("asyncRst", 32'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    #2;
    clrn = 1'b1;
    step(1'b1, 32'h77, 1'b0, 1'b0);
    chk_state("postRst", 32'h77, 1'b1, 1'b0, 3'd1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk_state("postRstPop", 32'h0, 1'b0, 1'b0, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_inst_queue.md
PIPE_INST_QUEUE -- requirements
Module: pipe_inst_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, instruction width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of entries; power of two, minimum 2.
REQ-003 SHALL have parameter NOP, default 0 (WIDTH bits), value presented when the queue is empty.
REQ-004 SHALL have clk  input  1  clock; all state changes on the rising edge.
REQ-005 SHALL have clrn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have flush  input  1  discard all entries (branch/exception redirect).
REQ-007 SHALL have push  input  1  write request from fetch.
REQ-008 SHALL have push_inst  input  WIDTH  instruction to write.
REQ-009 SHALL have pop  input  1  read/consume request from decode.
REQ-010 SHALL have out_inst  output  WIDTH  head entry, or NOP when empty.
REQ-011 SHALL have out_valid  output  1  queue non-empty.
REQ-012 SHALL have full  output  1  count equals DEPTH.
REQ-013 SHALL have count  output  clog2(DEPTH)+1  number of valid entries.
REQ-014 SHALL have ovf  output  1  sticky overflow flag.

Function
REQ-015 SHALL operate as a first-word-fall-through FIFO: out_inst is driven from registered head storage, with no combinational path from push_inst.
REQ-016 SHALL make a pushed instruction visible on out_inst one cycle after the push edge when the queue was empty (latency 1, no bypass).
REQ-017 SHALL accept a push when count < DEPTH, or when full and an accepted pop occurs in the same cycle.
REQ-018 SHALL accept a pop only when count > 0; a pop on an empty queue is ignored, with no pointer change.
REQ-019 SHALL, on push and pop in the same cycle while empty, accept the push only; count becomes 1.
REQ-020 SHALL, on push and pop in the same cycle with 0 < count ≤ DEPTH, accept both and leave count unchanged.
REQ-021 SHALL implement read and write pointers of clog2(DEPTH) bits that wrap modulo DEPTH with no gap.
REQ-022 SHALL, when push is refused (full, no pop), drop the data, leave storage unchanged, and set ovf.
REQ-023 SHALL clear ovf only on reset or flush.
REQ-024 SHALL give flush priority over push and pop: next cycle count=0, both pointers=0, out_valid=0, out_inst=NOP, ovf=0.
REQ-025 SHALL drive out_inst = NOP whenever out_valid=0, independent of stale storage contents.
REQ-026 SHALL drive full and out_valid as decodes of the registered count only.

Reset
REQ-027 SHALL, while clrn=0 and regardless of clk, force pointers=0, count=0, ovf=0, and all storage entries=NOP.
REQ-028 SHALL, during reset, present outputs out_valid=0, full=0, count=0, ovf=0, out_inst=NOP.
REQ-029 SHALL, when reset is asserted mid-operation, abandon all queued entries with no partial writes; the first edge after release behaves as from empty.

Verification
REQ-030 SHALL cover: reset, then push 0x11111111 -> next cycle out_valid=1, out_inst=0x11111111, count=1.
REQ-031 SHALL cover: 4 pushes 0xA0..0xA3 (DEPTH=4) -> full=1; 5th push 0xA4 -> dropped, ovf=1; 4 pops return 0xA0..0xA3 in order, then out_inst=NOP.
REQ-032 SHALL cover: full queue with push 0xB0 and pop together -> head advances, count stays 4, 0xB0 is returned last after wrap.
REQ-033 SHALL cover: count=3 with flush, push and pop together -> next cycle count=0, out_inst=NOP, ovf=0, pushed word absent.
REQ-034 SHALL cover: empty queue with pop only -> no change; empty queue with push 0xC0 and pop -> count=1, out_inst=0xC0.
REQ-035 SHALL cover: clrn pulsed low between clock edges with count=2 -> outputs immediately return to reset values.
